// File: rtl/dpram_pkg.sv
// rtl/dpram_pkg.sv - shared types and constants for the byte-enable dual-port RAM
package dpram_pkg;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

   function automatic int nbytes(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/dpram_be_pipe_if.sv
// rtl/dpram_be_pipe_if.sv - request/response bundle of the dual-port RAM
interface dpram_be_pipe_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 6
);

   logic                                  enb;
   logic                                  wr;
   logic [ADDR_W-1:0]                     w_addr;
   logic [DATA_W-1:0]                     w_data;
   logic [dpram_pkg::nbytes(DATA_W)-1:0]  w_be;
   logic                                  rd;
   logic [ADDR_W-1:0]                     r_addr;
   logic [DATA_W-1:0]                     r_data;
   logic                                  r_valid;
   logic                                  rdw_hit;
   logic                                  addr_err;
   logic                                  init_busy;

   modport master (
      output enb, wr, w_addr, w_data, w_be, rd, r_addr,
      input  r_data, r_valid, rdw_hit, addr_err, init_busy
   );

   modport slave (
      input  enb, wr, w_addr, w_data, w_be, rd, r_addr,
      output r_data, r_valid, rdw_hit, addr_err, init_busy
   );

endinterface

// File: rtl/dpram_core.sv
// rtl/dpram_core.sv - storage array with byte-enable write port and raw registered read port
module dpram_core #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 48
)(
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     w_addr,
   input  logic [DATA_W-1:0]     w_data,
   input  logic [DATA_W/8-1:0]   w_be,
   input  logic                  re,
   input  logic [ADDR_W-1:0]     r_addr,
   output logic [DATA_W-1:0]     r_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // byte-lane write; callers guarantee w_addr < DEPTH when we is high
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < DATA_W/8; i++) begin
            if (w_be[i]) mem[w_addr][8*i +: 8] <= w_data[8*i +: 8];
         end
      end
   end

   // raw read returns the word as it was before any same-edge write
   always_ff @(posedge clk) begin
      if (re) r_data <= mem[r_addr];
   end

endmodule

// File: rtl/dpram_be_pipe.sv
// rtl/dpram_be_pipe.sv - dual-port RAM with byte enables, clear sweep, RDW policy and 1/2-cycle read latency
module dpram_be_pipe
   import dpram_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 6,
   parameter int DEPTH    = 48,
   parameter int READ_LAT = 1,
   parameter int RDW_MODE = 0
)(
   input logic            clk,
   input logic            rst,
   dpram_be_pipe_if.slave bus
);

   localparam int              NB      = nbytes(DATA_W);
   localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

   if (DATA_W % 8 != 0)                    begin : g_chk_w   $error("DATA_W must be a multiple of 8"); end
   if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_chk_d   $error("DEPTH out of range for ADDR_W"); end
   if (READ_LAT != 1 && READ_LAT != 2)     begin : g_chk_lat $error("READ_LAT must be 1 or 2"); end

   state_t            state;
   logic [ADDR_W-1:0] init_ptr;
   logic              init_busy_q;
   logic              addr_err_q;

   logic run, w_acc, r_acc, w_in, r_in, w_ok, r_ok, hit;

   logic              c_we;
   logic [ADDR_W-1:0] c_waddr;
   logic [DATA_W-1:0] c_wdata;
   logic [NB-1:0]     c_wbe;
   logic [DATA_W-1:0] c_rdata;

   logic              s1_valid, s1_zero, s1_hit;
   logic [DATA_W-1:0] s1_wdata;
   logic [NB-1:0]     s1_be;
   logic [DATA_W-1:0] rd_word;

   assign run   = (state == ST_RUN) && !rst;
   assign w_acc = run && bus.enb && bus.wr;
   assign r_acc = run && bus.enb && bus.rd;
   assign w_in  = {1'b0, bus.w_addr} < DEPTH_V;
   assign r_in  = {1'b0, bus.r_addr} < DEPTH_V;
   assign w_ok  = w_acc && w_in;
   assign r_ok  = r_acc && r_in;
   assign hit   = w_ok && r_ok && (bus.w_addr == bus.r_addr);

   // clear sweep walks init_ptr through every word, then hands the array to the user ports
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_INIT;
         init_ptr    <= '0;
         init_busy_q <= 1'b1;
      end else if (state == ST_INIT) begin
         if (init_ptr == ADDR_W'(DEPTH - 1)) begin
            state       <= ST_RUN;
            init_busy_q <= 1'b0;
         end else begin
            init_ptr <= init_ptr + 1'b1;
         end
      end
   end

   // write port is owned by the sweep until it finishes
   always_comb begin
      c_we    = w_ok;
      c_waddr = bus.w_addr;
      c_wdata = bus.w_data;
      c_wbe   = bus.w_be;
      if (state == ST_INIT && !rst) begin
         c_we    = 1'b1;
         c_waddr = init_ptr;
         c_wdata = '0;
         c_wbe   = '1;
      end
   end

   dpram_core #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_core (
      .clk    (clk),
      .we     (c_we),
      .w_addr (c_waddr),
      .w_data (c_wdata),
      .w_be   (c_wbe),
      .re     (r_ok),
      .r_addr (bus.r_addr),
      .r_data (c_rdata)
   );

   // first read stage: remember how the accepted read must be post-processed; s1_zero also masks the unread core register after reset
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_zero  <= 1'b1;
         s1_hit   <= 1'b0;
         s1_wdata <= '0;
         s1_be    <= '0;
      end else begin
         s1_valid <= r_acc;
         if (r_acc) begin
            s1_zero  <= !r_in;
            s1_hit   <= hit;
            s1_wdata <= bus.w_data;
            s1_be    <= bus.w_be;
         end
      end
   end

   // out-of-range reads yield zero; in new-data mode a collision overlays the written bytes
   always_comb begin
      rd_word = '0;
      if (!s1_zero) begin
         rd_word = c_rdata;
         if (RDW_MODE == RDW_NEW && s1_hit) begin
            for (int i = 0; i < NB; i++) begin
               if (s1_be[i]) rd_word[8*i +: 8] = s1_wdata[8*i +: 8];
            end
         end
      end
   end

   // one pulse per cycle with any out-of-range accepted request
   always_ff @(posedge clk) begin
      if (rst) addr_err_q <= 1'b0;
      else     addr_err_q <= (w_acc && !w_in) || (r_acc && !r_in);
   end

   assign bus.addr_err  = addr_err_q;
   assign bus.init_busy = init_busy_q;

   if (READ_LAT == 1) begin : g_lat1
      assign bus.r_data  = rd_word;
      assign bus.r_valid = s1_valid;
      assign bus.rdw_hit = s1_valid && s1_hit;
   end else begin : g_lat2
      logic [DATA_W-1:0] r_data_q;
      logic              r_valid_q, rdw_hit_q;

      // extra output register; data holds between results
      always_ff @(posedge clk) begin
         if (rst) begin
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
            rdw_hit_q <= 1'b0;
         end else begin
            r_valid_q <= s1_valid;
            rdw_hit_q <= s1_valid && s1_hit;
            if (s1_valid) r_data_q <= rd_word;
         end
      end

      assign bus.r_data  = r_data_q;
      assign bus.r_valid = r_valid_q;
      assign bus.rdw_hit = rdw_hit_q;
   end

endmodule

// File: tb/tb_dpram_be_pipe.sv
// tb/tb_dpram_be_pipe.sv - scoreboard bench for three dpram_be_pipe configurations
module tb_dpram_be_pipe;

   typedef struct {
      logic [31:0] data;
      logic        hit;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        enb, wr, rd;
   logic [5:0]  w_addr, r_addr;
   logic [31:0] w_data;
   logic [3:0]  w_be;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   dpram_be_pipe_if #(.DATA_W(32), .ADDR_W(6)) if0();
   dpram_be_pipe_if #(.DATA_W(32), .ADDR_W(6)) if1();
   dpram_be_pipe_if #(.DATA_W(32), .ADDR_W(6)) if2();

   assign if0.enb = enb; assign if0.wr = wr; assign if0.w_addr = w_addr; assign if0.w_data = w_data;
   assign if0.w_be = w_be; assign if0.rd = rd; assign if0.r_addr = r_addr;
   assign if1.enb = enb; assign if1.wr = wr; assign if1.w_addr = w_addr; assign if1.w_data = w_data;
   assign if1.w_be = w_be; assign if1.rd = rd; assign if1.r_addr = r_addr;
   assign if2.enb = enb; assign if2.wr = wr; assign if2.w_addr = w_addr; assign if2.w_data = w_data;
   assign if2.w_be = w_be; assign if2.rd = rd; assign if2.r_addr = r_addr;

   dpram_be_pipe #(.READ_LAT(1), .RDW_MODE(0)) u0 (.clk(clk), .rst(rst), .bus(if0));
   dpram_be_pipe #(.READ_LAT(1), .RDW_MODE(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
   dpram_be_pipe #(.READ_LAT(2), .RDW_MODE(0)) u2 (.clk(clk), .rst(rst), .bus(if2));

   logic [2:0]  busy, err, vld, hitv;
   logic [31:0] rdat [3];
   assign busy = {if2.init_busy, if1.init_busy, if0.init_busy};
   assign err  = {if2.addr_err,  if1.addr_err,  if0.addr_err};
   assign vld  = {if2.r_valid,   if1.r_valid,   if0.r_valid};
   assign hitv = {if2.rdw_hit,   if1.rdw_hit,   if0.rdw_hit};
   assign rdat[0] = if0.r_data;
   assign rdat[1] = if1.r_data;
   assign rdat[2] = if2.r_data;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s dut%0d actual=%h required=%h cyc=%0d", nm, k, act, req, cyc);
      end
   endtask

   task automatic push(input int k, input logic [31:0] d, input logic h, input int lat);
      exp_t e;
      e.data = d;
      e.hit  = h;
      e.cyc  = cyc + lat;
      case (k)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic push_all(input logic [31:0] d, input logic h);
      push(0, d, h, 1);
      push(1, d, h, 1);
      push(2, d, h, 2);
   endtask

   task automatic mon(input int k, input logic [31:0] d, input logic h);
      exp_t e;
      int   n;
      case (k)
         0:       n = q0.size();
         1:       n = q1.size();
         default: n = q2.size();
      endcase
      if (n == 0) begin
         total++;
         bad++;
         $display("FAIL unexpected_r_valid dut%0d actual=1 required=0 data=%h cyc=%0d", k, d, cyc);
         return;
      end
      case (k)
         0:       e = q0.pop_front();
         1:       e = q1.pop_front();
         default: e = q2.pop_front();
      endcase
      chk("r_data",  k, d, e.data);
      chk("rdw_hit", k, {31'b0, h}, {31'b0, e.hit});
      chk("latency", k, 32'(cyc), 32'(e.cyc));
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (vld[k]) mon(k, rdat[k], hitv[k]);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sweep(input string nm);
      int   n [3];
      logic err_seen;
      n = '{0, 0, 0};
      err_seen = 1'b0;
      for (int t = 0; t < 200 && (busy != 3'b000); t++) begin
         for (int k = 0; k < 3; k++) begin
            if (busy[k]) n[k]++;
            if (err[k])  err_seen = 1'b1;
         end
         step();
      end
      wr = 1'b0;
      rd = 1'b0;
      for (int k = 0; k < 3; k++) chk(nm, k, 32'(n[k]), 32'd48);
      chk("addr_err_in_sweep", 0, {31'b0, err_seen}, 32'd0);
   endtask

   task automatic chk_err(input string nm, input logic req);
      for (int k = 0; k < 3; k++) chk(nm, k, {31'b0, err[k]}, {31'b0, req});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; enb = 1'b0; wr = 1'b0; rd = 1'b0;
      w_addr = '0; r_addr = '0; w_data = '0; w_be = '0;
      step();
      for (int k = 0; k < 3; k++) begin
         chk("rst_r_valid",   k, {31'b0, vld[k]},  32'd0);
         chk("rst_r_data",    k, rdat[k],          32'd0);
         chk("rst_init_busy", k, {31'b0, busy[k]}, 32'd1);
         chk("rst_addr_err",  k, {31'b0, err[k]},  32'd0);
      end

      // sweep with requests that must be ignored, including a write to addr 7
      rst = 1'b0;
      enb = 1'b1; wr = 1'b1; w_addr = 6'd7; w_data = 32'hFFFF_FFFF; w_be = 4'hF;
      rd = 1'b1; r_addr = 6'd7;
      sweep("sweep_len");

      for (int i = 0; i < 48; i++) begin
         rd = 1'b1; r_addr = 6'(i);
         push_all(32'h0, 1'b0);
         step();
      end
      rd = 1'b0;

      // byte-enable merge
      wr = 1'b1; w_addr = 6'd5; w_data = 32'hAABB_CCDD; w_be = 4'hF;
      step();
      w_data = 32'h1122_3344; w_be = 4'b0101;
      step();
      wr = 1'b0; rd = 1'b1; r_addr = 6'd5;
      push_all(32'hAA22_CC44, 1'b0);
      step();
      rd = 1'b0;

      // full-word collision
      wr = 1'b1; w_addr = 6'd3; w_data = 32'hDEAD_BEEF; w_be = 4'hF;
      rd = 1'b1; r_addr = 6'd3;
      push(0, 32'h0000_0000, 1'b1, 1);
      push(1, 32'hDEAD_BEEF, 1'b1, 1);
      push(2, 32'h0000_0000, 1'b1, 2);
      step();
      wr = 1'b0;
      push_all(32'hDEAD_BEEF, 1'b0);
      step();

      // partial-byte collision
      wr = 1'b1; w_addr = 6'd5; w_data = 32'h5500_0000; w_be = 4'b1000;
      r_addr = 6'd5;
      push(0, 32'hAA22_CC44, 1'b1, 1);
      push(1, 32'h5522_CC44, 1'b1, 1);
      push(2, 32'hAA22_CC44, 1'b1, 2);
      step();
      wr = 1'b0;
      push_all(32'h5522_CC44, 1'b0);
      step();
      rd = 1'b0;

      // out-of-range write, then read
      wr = 1'b1; w_addr = 6'd50; w_data = 32'hFFFF_FFFF; w_be = 4'hF;
      step();
      wr = 1'b0;
      chk_err("addr_err_wr", 1'b1);
      step();
      chk_err("addr_err_clear", 1'b0);
      rd = 1'b1; r_addr = 6'd63;
      push_all(32'h0, 1'b0);
      step();
      rd = 1'b0;
      chk_err("addr_err_rd", 1'b1);
      rd = 1'b1; r_addr = 6'd2;
      push_all(32'h0, 1'b0);
      step();
      rd = 1'b0;
      chk_err("addr_err_inrange", 1'b0);

      // both ports out of range at the same address: single pulse, no hit
      wr = 1'b1; w_addr = 6'd60; rd = 1'b1; r_addr = 6'd60;
      push_all(32'h0, 1'b0);
      step();
      wr = 1'b0; rd = 1'b0;
      chk_err("addr_err_both", 1'b1);
      step();
      chk_err("addr_err_single", 1'b0);

      // streaming reads
      wr = 1'b1; w_be = 4'hF;
      for (int i = 0; i < 3; i++) begin
         w_addr = 6'(i); w_data = 32'h100 * 32'(i + 1) + 32'(i);
         step();
      end
      wr = 1'b0;
      rd = 1'b1; r_addr = 6'd0; push_all(32'h0000_0100, 1'b0); step();
      r_addr = 6'd1;            push_all(32'h0000_0201, 1'b0); step();
      r_addr = 6'd2;            push_all(32'h0000_0302, 1'b0); step();
      rd = 1'b0;

      // enb low blocks both ports
      enb = 1'b0; wr = 1'b1; w_addr = 6'd1; w_data = 32'h0; rd = 1'b1; r_addr = 6'd1;
      step();
      step();
      enb = 1'b1; wr = 1'b0;
      push_all(32'h0000_0201, 1'b0);
      step();

      // pipeline drains while enb is low
      r_addr = 6'd2;
      push_all(32'h0000_0302, 1'b0);
      step();
      enb = 1'b0;
      step();
      step();
      enb = 1'b1; rd = 1'b0;

      // reset during an in-flight read: the 2-cycle instance must drop it
      rd = 1'b1; r_addr = 6'd0;
      push(0, 32'h0000_0100, 1'b0, 1);
      push(1, 32'h0000_0100, 1'b0, 1);
      step();
      rd = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0;

      // reset during the sweep restarts it
      rd = 1'b1; r_addr = 6'd5;
      repeat (20) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      sweep("sweep_restart_len");

      rd = 1'b1; r_addr = 6'd5;
      push_all(32'h0, 1'b0);
      step();
      rd = 1'b0;

      repeat (5) step();
      chk("queue_empty", 0, 32'(q0.size()), 32'd0);
      chk("queue_empty", 1, 32'(q1.size()), 32'd0);
      chk("queue_empty", 2, 32'(q2.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
